// File: rtl/dmem_arbiter_if.sv
// Bundle of the core, DMA and data-memory ports of the dmem arbiter.
// slave = arbiter view; master = requesters plus memory (bench side).
interface dmem_arbiter_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic [DATA_W-1:0] c_rdata;
  logic              c_stall;

  logic              d_valid;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;
  logic              d_rvalid;

  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wd;
  logic [DATA_W-1:0] m_rd;
  logic              grant_dma;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  d_valid, d_we, d_addr, d_wdata,
    input  m_rd,
    output c_rdata, c_stall,
    output d_ready, d_rdata, d_rvalid,
    output m_we, m_addr, m_wd,
    output grant_dma
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output d_valid, d_we, d_addr, d_wdata,
    output m_rd,
    input  c_rdata, c_stall,
    input  d_ready, d_rdata, d_rvalid,
    input  m_we, m_addr, m_wd,
    input  grant_dma
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port dmem arbiter: core has priority, a starvation counter forces DMA
// grants, and a granted DMA keeps priority for a bounded burst window.
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT  = 8,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);

  typedef enum logic {
    CORE_PRI  = 1'b0,
    DMA_BURST = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [BEAT_W-1:0] beat_cnt, beat_nxt;
  logic [BEAT_W-1:0] beat_inc;
  logic              wait_max;
  logic              grant;
  logic [31:0]       d_rdata_q;
  logic              d_rvalid_q;

  assign wait_max = (wait_cnt == WAIT_W'(MAX_WAIT));
  assign beat_inc = beat_cnt + BEAT_W'(1);

  // Grant decision, wait counter and burst window bookkeeping.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    beat_nxt  = beat_cnt;
    grant     = 1'b0;

    case (state)
      CORE_PRI:  grant = bus.d_valid & (~bus.c_req | wait_max);
      DMA_BURST: grant = bus.d_valid;
      default:   grant = 1'b0;
    endcase

    if (grant)            wait_nxt = '0;
    else if (bus.d_valid) wait_nxt = wait_max ? wait_cnt : wait_cnt + WAIT_W'(1);
    else                  wait_nxt = '0;

    case (state)
      CORE_PRI: begin
        // A one-beat window closes on the very beat that opened it.
        if (grant && (BEAT_W'(BURST_LEN) != BEAT_W'(1))) begin
          state_nxt = DMA_BURST;
          beat_nxt  = BEAT_W'(1);
        end else begin
          beat_nxt  = '0;
        end
      end
      DMA_BURST: begin
        if (!bus.d_valid || (beat_inc == BEAT_W'(BURST_LEN))) begin
          state_nxt = CORE_PRI;
          beat_nxt  = '0;
        end else begin
          beat_nxt  = beat_inc;
        end
      end
      default: begin
        state_nxt = CORE_PRI;
        beat_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CORE_PRI;
      wait_cnt   <= '0;
      beat_cnt   <= '0;
      d_rdata_q  <= '0;
      d_rvalid_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_nxt;
      beat_cnt   <= beat_nxt;
      d_rvalid_q <= grant & ~bus.d_we;
      if (grant & ~bus.d_we) d_rdata_q <= bus.m_rd;
    end
  end

  assign bus.grant_dma = grant;
  assign bus.d_ready   = grant;
  assign bus.c_stall   = bus.c_req & grant;
  assign bus.c_rdata   = bus.m_rd;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.m_addr    = grant ? bus.d_addr  : bus.c_addr;
  assign bus.m_wd      = grant ? bus.d_wdata : bus.c_wdata;
  assign bus.m_we      = ~reset & (grant ? bus.d_we : (bus.c_req & bus.c_we));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized run checked
// against a history-based reference model and a reference memory image.
module tb_dmem_arbiter;

  localparam int MAX_WAIT  = 8;
  localparam int BURST_LEN = 4;

  logic clk;
  logic reset;
  dmem_arbiter_if bus ();

  dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .BURST_LEN(BURST_LEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical memory behind the arbiter.
  logic [31:0] mem [256] = '{default: 32'h0};
  always @(posedge clk) if (bus.m_we) mem[bus.m_addr[9:2]] <= bus.m_wd;
  assign bus.m_rd = mem[bus.m_addr[9:2]];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: grant derived from access history, not from FSM states.
  logic [31:0] ref_mem [256] = '{default: 32'h0};
  bit          prev_hs;
  int          run;
  int          waited;
  logic        exp_rvalid;
  logic [31:0] exp_rdata;
  bit          last_grant;

  function automatic int widx(logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  function automatic bit grant_m();
    return bus.d_valid && ((prev_hs && run < BURST_LEN) || !bus.c_req || waited >= MAX_WAIT);
  endfunction

  task automatic model_reset();
    prev_hs = 0; run = 0; waited = 0;
    exp_rvalid = 1'b0; exp_rdata = 32'h0; last_grant = 0;
  endtask

  task automatic tick();
    bit g;
    g = grant_m();
    last_grant = g;
    if (g && !bus.d_we) begin
      exp_rvalid = 1'b1;
      exp_rdata  = ref_mem[widx(bus.d_addr)];
    end else begin
      exp_rvalid = 1'b0;
    end
    if (g && bus.d_we) ref_mem[widx(bus.d_addr)] = bus.d_wdata;
    else if (!g && bus.c_req && bus.c_we) ref_mem[widx(bus.c_addr)] = bus.c_wdata;
    if (g) begin
      run = (prev_hs && run < BURST_LEN) ? run + 1 : 1;
      prev_hs = 1;
    end else begin
      prev_hs = 0;
      run = 0;
    end
    waited = (g || !bus.d_valid) ? 0 : waited + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_addr = 32'h10; bus.c_wdata = 32'h1;
    bus.d_valid = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
    #12;
    n_cmp++; if (bus.m_we !== 1'b0) begin n_bad++; $display("FAIL reset_m_we: got %b exp 0", bus.m_we); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (bus.grant_dma !== 1'b0) begin n_bad++; $display("FAIL reset_grant: got %b exp 0", bus.grant_dma); end
    n_cmp++; if (bus.d_rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid: got %b exp 0", bus.d_rvalid); end
    n_cmp++; if (bus.d_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h exp 0", bus.d_rdata); end
    bus.c_req = 1'b0; bus.c_we = 1'b0;
    tick();
  endtask

  task automatic test_core_store();
    bus.c_req = 1'b0; bus.c_addr = 32'h44;
    @(negedge clk);
    n_cmp++; if (bus.m_we !== 1'b0 || bus.m_addr !== 32'h44) begin
      n_bad++; $display("FAIL idle_bus: got we %b addr %h exp we 0 addr 00000044", bus.m_we, bus.m_addr); end
    tick();
    bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_addr = 32'h40; bus.c_wdata = 32'hDEADBEEF;
    @(negedge clk);
    n_cmp++; if (bus.m_we !== 1'b1) begin n_bad++; $display("FAIL store_m_we: got %b exp 1", bus.m_we); end
    n_cmp++; if (bus.m_addr !== 32'h40) begin n_bad++; $display("FAIL store_m_addr: got %h exp 00000040", bus.m_addr); end
    n_cmp++; if (bus.c_stall !== 1'b0) begin n_bad++; $display("FAIL store_stall: got %b exp 0", bus.c_stall); end
    tick();
    bus.c_we = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.c_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL load_rdata: got %h exp deadbeef", bus.c_rdata); end
    tick();
    bus.c_req = 1'b0;
  endtask

  task automatic test_dma_read();
    bus.c_req = 1'b0;
    bus.d_valid = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
    @(negedge clk);
    n_cmp++; if (bus.d_ready !== 1'b1) begin n_bad++; $display("FAIL dma_rd_ready: got %b exp 1", bus.d_ready); end
    tick();
    bus.d_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.d_rvalid !== 1'b1) begin n_bad++; $display("FAIL dma_rd_rvalid: got %b exp 1", bus.d_rvalid); end
    n_cmp++; if (bus.d_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL dma_rd_data: got %h exp deadbeef", bus.d_rdata); end
    tick();
    @(negedge clk);
    n_cmp++; if (bus.d_rvalid !== 1'b0) begin n_bad++; $display("FAIL dma_rd_single_pulse: got %b exp 0", bus.d_rvalid); end
    n_cmp++; if (bus.d_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL dma_rd_hold: got %h exp deadbeef", bus.d_rdata); end
    tick();
  endtask

  task automatic test_starvation_burst();
    int beat;
    int last;
    bit ex;
    beat = 0;
    last = 2 * MAX_WAIT + BURST_LEN;
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h80;
    bus.d_valid = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h100; bus.d_wdata = 32'hA5000000;
    for (int cyc = 0; cyc <= last; cyc++) begin
      ex = (cyc >= MAX_WAIT && cyc < MAX_WAIT + BURST_LEN) || cyc == last;
      @(negedge clk);
      n_cmp++; if (bus.d_ready !== ex) begin n_bad++; $display("FAIL starve_ready cyc %0d: got %b exp %b", cyc, bus.d_ready, ex); end
      n_cmp++; if (bus.c_stall !== ex) begin n_bad++; $display("FAIL starve_stall cyc %0d: got %b exp %b", cyc, bus.c_stall, ex); end
      tick();
      if (ex) begin
        beat++;
        bus.d_addr  = 32'h100 + 32'(4 * beat);
        bus.d_wdata = 32'hA5000000 | 32'(beat);
      end
    end
    bus.d_valid = 1'b0;
    bus.c_addr = 32'h104;
    @(negedge clk);
    n_cmp++; if (bus.c_rdata !== 32'hA5000001 || bus.c_stall !== 1'b0) begin
      n_bad++; $display("FAIL burst_data: got %h stall %b exp a5000001 stall 0", bus.c_rdata, bus.c_stall); end
    tick();
    bus.c_req = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h80;
    bus.d_valid = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
    for (int cyc = 0; cyc <= MAX_WAIT + 1; cyc++) begin
      @(negedge clk);
      n_cmp++; if (bus.d_ready !== (cyc >= MAX_WAIT)) begin
        n_bad++; $display("FAIL midrst_pre_ready cyc %0d: got %b exp %b", cyc, bus.d_ready, cyc >= MAX_WAIT); end
      if (cyc < MAX_WAIT + 1) tick();
    end
    n_cmp++; if (bus.d_rvalid !== 1'b1) begin n_bad++; $display("FAIL midrst_beat1_rvalid: got %b exp 1", bus.d_rvalid); end
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.d_rvalid !== 1'b0) begin n_bad++; $display("FAIL midrst_rvalid: got %b exp 0", bus.d_rvalid); end
    n_cmp++; if (bus.d_rdata !== 32'h0) begin n_bad++; $display("FAIL midrst_rdata: got %h exp 0", bus.d_rdata); end
    n_cmp++; if (bus.grant_dma !== 1'b0 || bus.c_stall !== 1'b0) begin
      n_bad++; $display("FAIL midrst_grant: got grant %b stall %b exp 0 0", bus.grant_dma, bus.c_stall); end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int cyc = 0; cyc <= MAX_WAIT; cyc++) begin
      @(negedge clk);
      n_cmp++; if (bus.d_ready !== (cyc == MAX_WAIT)) begin
        n_bad++; $display("FAIL midrst_post_ready cyc %0d: got %b exp %b", cyc, bus.d_ready, cyc == MAX_WAIT); end
      if (cyc == 0) begin
        n_cmp++; if (bus.d_rvalid !== 1'b0) begin n_bad++; $display("FAIL midrst_uncommitted: got %b exp 0", bus.d_rvalid); end
      end
      tick();
    end
    bus.d_valid = 1'b0; bus.c_req = 1'b0;
    tick();
  endtask

  task automatic test_random();
    bit g;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    for (int i = 0; i < 800; i++) begin
      if (!(bus.c_req && last_grant)) begin
        bus.c_req   = ($urandom_range(0, 9) < 7);
        bus.c_we    = 1'($urandom_range(0, 1));
        bus.c_addr  = 32'($urandom_range(0, 15) * 4);
        bus.c_wdata = $urandom;
      end
      if (!(bus.d_valid && !last_grant)) begin
        bus.d_valid = ($urandom_range(0, 9) < 6);
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_addr  = 32'($urandom_range(0, 15) * 4);
        bus.d_wdata = $urandom;
      end
      @(negedge clk);
      g      = grant_m();
      e_we   = g ? bus.d_we : (bus.c_req & bus.c_we);
      e_addr = g ? bus.d_addr : bus.c_addr;
      e_wd   = g ? bus.d_wdata : bus.c_wdata;
      n_cmp++; if (bus.grant_dma !== g || bus.d_ready !== g) begin
        n_bad++; $display("FAIL rnd_grant cyc %0d: got grant %b ready %b exp %b", i, bus.grant_dma, bus.d_ready, g); end
      n_cmp++; if (bus.c_stall !== (bus.c_req & g)) begin
        n_bad++; $display("FAIL rnd_stall cyc %0d: got %b exp %b", i, bus.c_stall, bus.c_req & g); end
      n_cmp++; if (bus.m_we !== e_we || bus.m_addr !== e_addr || bus.m_wd !== e_wd) begin
        n_bad++; $display("FAIL rnd_mux cyc %0d: got %b %h %h exp %b %h %h", i, bus.m_we, bus.m_addr, bus.m_wd, e_we, e_addr, e_wd); end
      n_cmp++; if (bus.d_rvalid !== exp_rvalid || bus.d_rdata !== exp_rdata) begin
        n_bad++; $display("FAIL rnd_dma_rd cyc %0d: got %b %h exp %b %h", i, bus.d_rvalid, bus.d_rdata, exp_rvalid, exp_rdata); end
      if (bus.c_req && !bus.c_we && !g) begin
        n_cmp++; if (bus.c_rdata !== ref_mem[widx(bus.c_addr)]) begin
          n_bad++; $display("FAIL rnd_core_ld cyc %0d: got %h exp %h", i, bus.c_rdata, ref_mem[widx(bus.c_addr)]); end
      end
      if ($urandom_range(0, 149) == 0) begin
        reset = 1'b1;
        #1;
        n_cmp++; if (bus.m_we !== 1'b0 || bus.d_rvalid !== 1'b0) begin
          n_bad++; $display("FAIL rnd_reset cyc %0d: got we %b rvalid %b exp 0 0", i, bus.m_we, bus.d_rvalid); end
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
      end else begin
        tick();
      end
    end
    bus.c_req = 1'b0; bus.d_valid = 1'b0;
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_core_store();
    test_dma_read();
    test_starvation_burst();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
